mem_lsu: RTL and testbench

- Memory-access stage directly downstream of the execute stage, fed by the ex/mem pipeline register.
- Consumes the per-instruction ALU op, effective address, store data (rs2) and writeback info.
- Performs RV32I loads/stores over a simple req/ack data bus and produces final writeback data for the mem/wb register.
- Non-memory instructions pass through unchanged; memory instructions hold the pipeline with stallreq_o until the bus completes.

---
 rtl/mem_lsu_pkg.sv | 26 ++
 rtl/mem_lsu_align.sv | 71 +++++++
 rtl/mem_lsu.sv | 175 +++++++++++++++++
 tb/tb_mem_lsu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: aluop codes, op-bus width,
// stall levels and LSU state encodings.
package mem_lsu_pkg;

  localparam int ALU_OP_BUS_W = 8;

  localparam logic [ALU_OP_BUS_W-1:0] EXE_ADD = 8'h20;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LB  = 8'hE0;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LH  = 8'hE1;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LW  = 8'hE3;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LBU = 8'hE4;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LHU = 8'hE5;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_SB  = 8'hE8;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_SH  = 8'hE9;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_SW  = 8'hEB;

  localparam logic StallEnable  = 1'b1;
  localparam logic StallDisable = 1'b0;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic for the LSU: byte-lane select, store-data
// replication and load extraction with sign/zero extension.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int ALUOP_W = ALU_OP_BUS_W
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [1:0]         addr,
  input  logic [31:0]        reg2,
  input  logic [31:0]        rdata,
  output logic               is_load,
  output logic               is_store,
  output logic [3:0]         sel,
  output logic [31:0]        st_data,
  output logic [31:0]        ld_data
);

  logic [1:0]  size;  // 0 byte, 1 half, 2 word
  logic        sext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd2;
    sext     = 1'b0;
    case (aluop)
      ALUOP_W'(EXE_LB):  begin is_load  = 1'b1; size = 2'd0; sext = 1'b1; end
      ALUOP_W'(EXE_LH):  begin is_load  = 1'b1; size = 2'd1; sext = 1'b1; end
      ALUOP_W'(EXE_LW):  begin is_load  = 1'b1; size = 2'd2; end
      ALUOP_W'(EXE_LBU): begin is_load  = 1'b1; size = 2'd0; end
      ALUOP_W'(EXE_LHU): begin is_load  = 1'b1; size = 2'd1; end
      ALUOP_W'(EXE_SB):  begin is_store = 1'b1; size = 2'd0; end
      ALUOP_W'(EXE_SH):  begin is_store = 1'b1; size = 2'd1; end
      ALUOP_W'(EXE_SW):  begin is_store = 1'b1; size = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    case (addr)
      2'd0:    ld_b = rdata[7:0];
      2'd1:    ld_b = rdata[15:8];
      2'd2:    ld_b = rdata[23:16];
      default: ld_b = rdata[31:24];
    endcase
    // Halfword lanes follow addr[1] only, so a misaligned halfword lands on its half.
    ld_h = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      2'd0: begin
        sel     = 4'b0001 << addr;
        st_data = {4{reg2[7:0]}};
        ld_data = {{24{sext & ld_b[7]}}, ld_b};
      end
      2'd1: begin
        sel     = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{reg2[15:0]}};
        ld_data = {{16{sext & ld_h[15]}}, ld_h};
      end
      default: begin
        sel     = 4'b1111;
        st_data = reg2;
        ld_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// RV32I memory-access stage: req/ack bus master with stall and timeout.
// Optional macro MEM_LSU_MISALIGN_TRAP_EN turns misaligned accesses into trap reports.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ALUOP_W     = ALU_OP_BUS_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_reg2_i,
  input  logic [4:0]         wd_i,
  input  logic               wreg_i,
  input  logic [31:0]        wdata_i,
  output logic [4:0]         wd_o,
  output logic               wreg_o,
  output logic [31:0]        wdata_o,
  output logic               stallreq_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [31:0]        bus_addr_o,
  output logic [3:0]         bus_sel_o,
  output logic [31:0]        bus_wdata_o,
  input  logic               bus_ack_i,
  input  logic [31:0]        bus_rdata_i,
  output logic               bus_err_o
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  ,
  output logic               misalign_o,
  output logic [31:0]        misalign_addr_o
`endif
);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_load, is_store, is_mem;
  logic [3:0]  sel;
  logic [31:0] ld_data;

  mem_lsu_align #(.ALUOP_W(ALUOP_W)) u_align (
    .aluop    (aluop_i),
    .addr     (mem_addr_i[1:0]),
    .reg2     (mem_reg2_i),
    .rdata    (rdata_q),
    .is_load  (is_load),
    .is_store (is_store),
    .sel      (sel),
    .st_data  (bus_wdata_o),
    .ld_data  (ld_data)
  );

  assign is_mem     = is_load | is_store;
  assign bus_addr_o = {mem_addr_i[31:2], 2'b00};

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic misaligned;
  assign misaligned =
    (((aluop_i == ALUOP_W'(EXE_LH)) || (aluop_i == ALUOP_W'(EXE_LHU)) ||
      (aluop_i == ALUOP_W'(EXE_SH))) && mem_addr_i[0]) ||
    (((aluop_i == ALUOP_W'(EXE_LW)) || (aluop_i == ALUOP_W'(EXE_SW))) &&
      (mem_addr_i[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_sel_o   = 4'b0000;
    stallreq_o  = StallDisable;
    bus_err_o   = 1'b0;
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    mis_d           = mis_q;
    misalign_o      = 1'b0;
    misalign_addr_o = 32'd0;
`endif
    // Outputs stay at their idle values for as long as reset is held.
    if (!rst) begin
      case (state_q)
        LSU_IDLE: begin
          if (!is_mem) begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else begin
            stallreq_o = StallEnable;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
            if (misaligned) begin
              mis_d   = 1'b1;
              state_d = LSU_DONE;
            end else
`endif
            begin
              bus_req_o = 1'b1;
              bus_we_o  = is_store;
              bus_sel_o = sel;
              // The IDLE cycle counts as the first wait cycle.
              if (bus_ack_i) begin
                rdata_d = bus_rdata_i;
                state_d = LSU_DONE;
              end else begin
                cnt_d   = 8'd1;
                state_d = LSU_WAIT;
              end
            end
          end
        end
        LSU_WAIT: begin
          stallreq_o = StallEnable;
          bus_req_o  = 1'b1;
          bus_we_o   = is_store;
          bus_sel_o  = sel;
          if (bus_ack_i) begin
            rdata_d = bus_rdata_i;
            state_d = LSU_DONE;
          end else if (cnt_q == 8'(TIMEOUT_CYC)) begin
            err_d   = 1'b1;
            state_d = LSU_DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        LSU_DONE: begin
          bus_err_o = err_q;
          if (is_load) begin
            wreg_o  = wreg_i;
            wdata_o = err_q ? 32'd0 : ld_data;
          end
`ifdef MEM_LSU_MISALIGN_TRAP_EN
          if (mis_q) begin
            wreg_o          = 1'b0;
            wdata_o         = 32'd0;
            misalign_o      = 1'b1;
            misalign_addr_o = mem_addr_i;
          end
          mis_d = 1'b0;
`endif
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = LSU_IDLE;
        end
        default: state_d = LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu with a transaction-level reference model and
// directed cases for pass-through, loads, stores, timeout and reset.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, mem_reg2_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, bus_req_o, bus_we_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  int tests = 0;
  int fails = 0;

  mem_lsu #(.ALUOP_W(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .mem_reg2_i(mem_reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o)
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Access size in bytes; 0 means the op does not touch memory.
  function automatic int op_size(input logic [7:0] op);
    if (op == EXE_LB || op == EXE_LBU || op == EXE_SB) return 1;
    if (op == EXE_LH || op == EXE_LHU || op == EXE_SH) return 2;
    if (op == EXE_LW || op == EXE_SW) return 4;
    return 0;
  endfunction

  // One instruction: the model predicts the full transaction, then each cycle
  // of it is compared. lat = index of the request cycle carrying ack.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdat,
                        input logic [31:0] rdata, input int lat,
                        input bit lit, input logic [31:0] lit_wdata, input int lit_nstall);
    int          sz, off, nstall, seen;
    bit          st, sgn, tmo;
    longint      v, mask;
    logic [31:0] esel, ebw, eres;
    sz  = op_size(op);
    st  = (op == EXE_SB || op == EXE_SH || op == EXE_SW);
    sgn = (op == EXE_LB || op == EXE_LH);
    @(posedge clk); #1;
    aluop_i = op; mem_addr_i = addr; mem_reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = wdat;
    if (sz == 0) begin
      bus_ack_i   = 1'($urandom_range(0, 1));
      bus_rdata_i = $urandom;
      @(negedge clk);
      chk("alu_wdata", wdata_o, wdat);
      chk("alu_wreg", wreg_o, wreg);
      chk("alu_wd", wd_o, wd);
      chk("alu_stall", stallreq_o, 0);
      chk("alu_req", bus_req_o, 0);
      chk("alu_err", bus_err_o, 0);
      if (lit) chk("alu_lit", wdata_o, lit_wdata);
      return;
    end
    off  = (sz == 1) ? int'(addr % 4) : (sz == 2) ? int'((addr % 4) / 2) * 2 : 0;
    esel = 32'(((1 << sz) - 1) << off);
    ebw  = (sz == 1) ? (reg2 & 32'hFF) * 32'h0101_0101 :
           (sz == 2) ? (reg2 & 32'hFFFF) * 32'h0001_0001 : reg2;
    v    = longint'(rdata) >> (8 * off);
    mask = (64'd1 << (8 * sz)) - 1;
    v    = v & mask;
    if (sgn && v >= (mask + 1) / 2) v = v - (mask + 1);
    eres = 32'(v);
    tmo    = (lat > TMO);
    nstall = tmo ? TMO + 1 : lat + 1;
    seen   = 0;
    for (int k = 0; k <= nstall; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < nstall) begin
        bus_ack_i   = (k == lat);
        bus_rdata_i = (k == lat) ? rdata : $urandom;
      end else begin
        bus_ack_i   = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom;
      end
      @(negedge clk);
      if (stallreq_o === 1'b1) seen++;
      if (k < nstall) begin
        chk("acc_stall", stallreq_o, 1);
        chk("acc_req", bus_req_o, 1);
        chk("acc_we", bus_we_o, st);
        chk("acc_sel", bus_sel_o, esel);
        chk("acc_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
        if (st) chk("acc_bwdata", bus_wdata_o, ebw);
        chk("acc_err", bus_err_o, 0);
      end else begin
        chk("done_stall", stallreq_o, 0);
        chk("done_req", bus_req_o, 0);
        chk("done_err", bus_err_o, tmo);
        chk("done_wd", wd_o, wd);
        chk("done_wreg", wreg_o, st ? 1'b0 : wreg);
        chk("done_wdata", wdata_o, (st || tmo) ? 32'd0 : eres);
        if (lit) begin
          chk("lit_wdata", wdata_o, lit_wdata);
          chk("lit_nstall", seen, lit_nstall);
        end
      end
    end
    bus_ack_i = 1'b0;
  endtask

  logic [7:0] op_tab [10];

  initial begin
    op_tab = '{EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW, EXE_ADD, 8'h11};
    rst = 1'b1;
    aluop_i = EXE_LW; mem_addr_i = 32'h0000_1000; mem_reg2_i = 32'h1;
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus_req_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_we", bus_we_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = EXE_ADD;

    // Directed cases with hand-computed results.
    run_op(EXE_ADD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 1'b1, 32'h0000_1234, 0);
    run_op(EXE_LB,  32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 32'h80FF_0000, 0, 1'b1, 32'hFFFF_FF80, 1);
    run_op(EXE_LBU, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h0, 32'h80FF_0000, 0, 1'b1, 32'h0000_0080, 1);
    run_op(EXE_SH,  32'h2002, 32'hABCD_1234, 5'd9, 1'b1, 32'h0, 32'h0, 3, 1'b1, 32'h0, 4);
    run_op(EXE_LW,  32'h3000, 32'h0, 5'd2, 1'b1, 32'h0, 32'h1111_2222, 99, 1'b1, 32'h0, 5);
    run_op(EXE_LH,  32'h0002, 32'h0, 5'd4, 1'b1, 32'h0, 32'h8001_7FFF, 1, 1'b1, 32'hFFFF_8001, 2);

    // Reset while waiting on the bus, followed by a stray ack.
    @(posedge clk); #1;
    aluop_i = EXE_LW; mem_addr_i = 32'h4000; bus_ack_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_pre_stall", stallreq_o, 1);
    @(posedge clk); #1;
    rst = 1'b1; aluop_i = EXE_ADD; wreg_i = 1'b1; wdata_i = 32'h55;
    @(negedge clk);
    chk("rstw_req", bus_req_o, 0);
    chk("rstw_stall", stallreq_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstw_post_req", bus_req_o, 0);
    chk("rstw_post_stall", stallreq_o, 0);
    chk("rstw_post_wdata", wdata_o, 32'h55);
    chk("rstw_post_err", bus_err_o, 0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("rstw_late_req", bus_req_o, 0);
    chk("rstw_late_wreg", wreg_o, 1);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    aluop_i = EXE_LW; mem_addr_i = 32'h1001; wreg_i = 1'b1;
    @(negedge clk);
    chk("mis_req", bus_req_o, 0);
    chk("mis_stall", stallreq_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_pulse", misalign_o, 1);
    chk("mis_addr", misalign_addr_o, 32'h1001);
    chk("mis_wreg", wreg_o, 0);
    chk("mis_stall_done", stallreq_o, 0);
    @(posedge clk); #1;
    aluop_i = EXE_ADD;
`endif

    for (int n = 0; n < 300; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int          sz;
      op = op_tab[$urandom_range(0, 9)];
      a  = $urandom;
      sz = op_size(op);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      if (sz > 1) a = a & ~32'(sz - 1);
`endif
      run_op(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom,
             $urandom_range(0, 6), 1'b0, 32'h0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
